// File: rtl/cu_pkg.sv
// ---------------------------------------------------------------------------
// cu_pkg : FSM states, opcode encodings and instruction field helpers
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALTED = 3'd4,
    ST_WAIT   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    OPC_NOP   = 3'd0,
    OPC_LOAD  = 3'd1,
    OPC_STORE = 3'd2,
    OPC_ADD   = 3'd3,
    OPC_SUB   = 3'd4,
    OPC_HALT  = 3'd5
  } op_e;

  localparam int unsigned IR_W = 12;

  localparam logic [2:0] OPCODE_LOAD  = 3'b000;
  localparam logic [2:0] OPCODE_STORE = 3'b001;
  localparam logic [2:0] OPCODE_ADD   = 3'b101;
  localparam logic [2:0] OPCODE_SUB   = 3'b110;
  localparam logic [2:0] OPCODE_HALT  = 3'b111;

  localparam int unsigned OPCODE_LSB = 9;
  localparam int unsigned RD_LSB     = 6;
  localparam int unsigned RA_LSB     = 3;
  localparam int unsigned RB_LSB     = 0;
  localparam int unsigned ADDR_LSB   = 0;

  function automatic logic [2:0] f_opcode(input logic [IR_W-1:0] ir);
    return ir[OPCODE_LSB +: 3];
  endfunction

  function automatic logic [2:0] f_rd(input logic [IR_W-1:0] ir);
    return ir[RD_LSB +: 3];
  endfunction

  function automatic logic [2:0] f_ra(input logic [IR_W-1:0] ir);
    return ir[RA_LSB +: 3];
  endfunction

  function automatic logic [2:0] f_rb(input logic [IR_W-1:0] ir);
    return ir[RB_LSB +: 3];
  endfunction

  function automatic logic [3:0] f_addr(input logic [IR_W-1:0] ir);
    return ir[ADDR_LSB +: 4];
  endfunction

  function automatic op_e decode_op(input logic [IR_W-1:0] ir);
    op_e op;
    case (f_opcode(ir))
      OPCODE_LOAD:  op = OPC_LOAD;
      OPCODE_STORE: op = OPC_STORE;
      OPCODE_ADD:   op = OPC_ADD;
      OPCODE_SUB:   op = OPC_SUB;
      OPCODE_HALT:  op = OPC_HALT;
      default:      op = OPC_NOP;
    endcase
    return op;
  endfunction

endpackage

`default_nettype wire

// File: rtl/control_unit_if.sv
// ---------------------------------------------------------------------------
// control_unit_if : control unit <-> datapath / instruction memory bundle
// Optional `step` signal present when CU_SINGLE_STEP_EN is defined.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface control_unit_if #(
  parameter int PC_W = 4,
  parameter int DA_W = 4
);

`ifdef CU_SINGLE_STEP_EN
  logic            step;
`endif
  logic            start;
  logic [11:0]     ir_q;
  logic [PC_W-1:0] imem_addr;
  logic            ir_ld;
  logic [2:0]      rf_raddr_a;
  logic [2:0]      rf_raddr_b;
  logic [2:0]      rf_waddr;
  logic            rf_we;
  logic            wsel;
  logic            alu_sub;
  logic [DA_W-1:0] dmem_addr;
  logic            dmem_we;
  logic            busy;
  logic            halted;

  modport master (
`ifdef CU_SINGLE_STEP_EN
    input  step,
`endif
    input  start, ir_q,
    output imem_addr, ir_ld, rf_raddr_a, rf_raddr_b, rf_waddr, rf_we,
    output wsel, alu_sub, dmem_addr, dmem_we, busy, halted
  );

  modport slave (
`ifdef CU_SINGLE_STEP_EN
    output step,
`endif
    output start, ir_q,
    input  imem_addr, ir_ld, rf_raddr_a, rf_raddr_b, rf_waddr, rf_we,
    input  wsel, alu_sub, dmem_addr, dmem_we, busy, halted
  );

endinterface

`default_nettype wire

// File: rtl/cu_decoder.sv
// ---------------------------------------------------------------------------
// cu_decoder : combinational datapath control from latched op class and IR
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cu_decoder
  import cu_pkg::*;
#(
  parameter int DA_W = 4
) (
  input  wire logic            decode_i,
  input  wire logic            exec_i,
  input  wire logic            wr_block_i,
  input  op_e                  op_i,
  input  wire logic [11:0]     ir_i,
  output logic      [2:0]      rf_raddr_a_o,
  output logic      [2:0]      rf_raddr_b_o,
  output logic      [2:0]      rf_waddr_o,
  output logic                 rf_we_o,
  output logic                 wsel_o,
  output logic                 alu_sub_o,
  output logic      [DA_W-1:0] dmem_addr_o,
  output logic                 dmem_we_o
);

  always_comb begin
    rf_raddr_a_o = '0;
    rf_raddr_b_o = '0;
    rf_waddr_o   = '0;
    rf_we_o      = 1'b0;
    wsel_o       = 1'b0;
    alu_sub_o    = 1'b0;
    dmem_addr_o  = '0;
    dmem_we_o    = 1'b0;

    if (decode_i) begin
      rf_raddr_a_o = f_ra(ir_i);
      rf_raddr_b_o = f_rb(ir_i);
    end

    // Write strobes drop while reset is asserted so an interrupted EXEC never commits.
    if (exec_i) begin
      case (op_i)
        OPC_LOAD: begin
          dmem_addr_o = DA_W'(f_addr(ir_i));
          wsel_o      = 1'b0;
          rf_waddr_o  = f_rd(ir_i);
          rf_we_o     = ~wr_block_i;
        end
        OPC_STORE: begin
          rf_raddr_a_o = f_rd(ir_i);
          dmem_addr_o  = DA_W'(f_addr(ir_i));
          dmem_we_o    = ~wr_block_i;
        end
        OPC_ADD, OPC_SUB: begin
          rf_raddr_a_o = f_ra(ir_i);
          rf_raddr_b_o = f_rb(ir_i);
          wsel_o       = 1'b1;
          alu_sub_o    = (op_i == OPC_SUB);
          rf_waddr_o   = f_rd(ir_i);
          rf_we_o      = ~wr_block_i;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit : 3-cycle fetch/decode/execute sequencer with PC
// Optional single-step gating via CU_SINGLE_STEP_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module control_unit
  import cu_pkg::*;
#(
  parameter int PC_W = 4,
  parameter int DA_W = 4
) (
  input  wire logic      clk,
  input  wire logic      rst,
  control_unit_if.master bus
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  op_e             op_q, op_d;
  logic            step_ok;

`ifdef CU_SINGLE_STEP_EN
  assign step_ok = bus.step;
`else
  assign step_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      op_q    <= OPC_NOP;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (bus.start) state_d = step_ok ? ST_FETCH : ST_WAIT;
      end
      ST_WAIT: begin
        if (step_ok) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        pc_d    = pc_q + PC_W'(1);
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        op_d    = decode_op(bus.ir_q);
        state_d = (op_d == OPC_HALT) ? ST_HALTED : ST_EXEC;
      end
      ST_EXEC: begin
        state_d = step_ok ? ST_FETCH : ST_WAIT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.imem_addr = pc_q;
  assign bus.ir_ld     = (state_q == ST_FETCH);
  assign bus.busy      = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                         (state_q == ST_EXEC)  || (state_q == ST_WAIT);
  assign bus.halted    = (state_q == ST_HALTED);

  cu_decoder #(
    .DA_W (DA_W)
  ) u_decoder (
    .decode_i     (state_q == ST_DECODE),
    .exec_i       (state_q == ST_EXEC),
    .wr_block_i   (rst),
    .op_i         (op_q),
    .ir_i         (bus.ir_q),
    .rf_raddr_a_o (bus.rf_raddr_a),
    .rf_raddr_b_o (bus.rf_raddr_b),
    .rf_waddr_o   (bus.rf_waddr),
    .rf_we_o      (bus.rf_we),
    .wsel_o       (bus.wsel),
    .alu_sub_o    (bus.alu_sub),
    .dmem_addr_o  (bus.dmem_addr),
    .dmem_we_o    (bus.dmem_we)
  );

endmodule

`default_nettype wire

// File: doc/control_unit.md
# control_unit

Fetch/decode/execute sequencer for the 12-bit simple processor. Drives the instruction-memory address and the `IR` load strobe, then, from the loaded instruction, generates register-file, data-memory and ALU control for one instruction every three cycles. Sits between the program counter/instruction memory and the datapath (IR, register file, ALU, data memory).

## Interface
- `PC_W`, 4: program counter / instruction-memory address width (16 words).
- `DA_W`, 4: data-memory address width.
- `clk` in 1: single clock; everything updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: leave IDLE/HALTED and begin fetching; ignored while running.
- `step` in 1: advance permission (only with `CU_SINGLE_STEP_EN`).
- `ir_q` in 12: current `IR` contents.
- `imem_addr` out PC_W: instruction-memory address (= PC).
- `ir_ld` out 1: `IR` load enable.
- `rf_raddr_a`, `rf_raddr_b` out 3: register-file read addresses.
- `rf_waddr` out 3; `rf_we` out 1: register-file write port.
- `wsel` out 1: write-data select, 0 = data memory, 1 = ALU.
- `alu_sub` out 1: 0 = add, 1 = subtract.
- `dmem_addr` out DA_W; `dmem_we` out 1: data-memory port.
- `busy` out 1: high in FETCH/DECODE/EXEC.
- `halted` out 1: high in HALTED.

## Operation
- Instruction: opcode `ir[11:9]`, rd/rs `ir[8:6]`, ra `ir[5:3]`, rb `ir[2:0]`, addr `ir[3:0]`.
- Opcodes: 000 LOAD rd←dmem[addr]; 001 STORE dmem[addr]←rs; 101 ADD rd←ra+rb; 110 SUB rd←ra−rb; 111 HALT; 010/011/100 NOP.
- States: IDLE → (start) FETCH → DECODE → EXEC → FETCH; DECODE with HALT → HALTED; HALTED → (start) FETCH, PC unchanged (resumes after HALT).
- FETCH: `imem_addr`=PC, `ir_ld`=1; PC increments at the edge, 4'hF wraps to 0.
- DECODE: `ir_q` valid; opcode class latched into internal `op_q`; `rf_raddr_a`=ra, `rf_raddr_b`=rb.
- EXEC: LOAD: `dmem_addr`=addr, `wsel`=0, `rf_waddr`=rd, `rf_we`=1. STORE: `rf_raddr_a`=rs, `dmem_addr`=addr, `dmem_we`=1. ADD/SUB: read addrs held, `wsel`=1, `alu_sub` per op, `rf_we`=1. NOP: no enables.
- `rf_we`, `dmem_we`, `ir_ld` are never high outside their single state; at most one of `rf_we`/`dmem_we` per cycle.
- `start` during FETCH/DECODE/EXEC has no effect.

## Timing
- Reset (any state, any cycle): state=IDLE, PC=0, `op_q`=NOP; all enables 0, all addresses 0, `wsel`=0, `alu_sub`=0, `busy`=0, `halted`=0 in the cycle after the reset edge. Mid-instruction reset discards it with no write.
- Outputs are Moore decodes of state, PC and `op_q`/`ir_q`; no extra register stage.
- Latency: `start` sampled high in IDLE → FETCH next cycle; first write occurs at the end of the third cycle after that.
- Throughput: exactly 3 cycles per instruction, including NOP; HALT enters HALTED after DECODE (2 cycles).
- `start` and `rst` together: `rst` wins.

## Configuration
- `CU_SINGLE_STEP_EN` defined: `step` port exists; FETCH is entered from EXEC (and from IDLE/HALTED after `start`) only when `step`=1 in that cycle, else the controller waits in a WAIT state with all enables 0 and `busy`=1. One instruction per step pulse.
- Undefined: no `step` port; free-running as above.

## Structure
- `cu_pkg`: state enum (IDLE, FETCH, DECODE, EXEC, HALTED, WAIT), opcode localparams, field-slice constants.
- Sub-module `cu_decoder`: combinational `op_q` + `ir_q` → datapath control signals; top holds FSM and PC.

## Test plan
- Reset: `rst`=1 for 2 cycles mid-EXEC of ADD → no `rf_we`, `imem_addr`=0, all outputs 0.
- `ir_q`=12'b101_011_001_010 (ADD r3,r1,r2) after `start` → `ir_ld` in cycle 1, `rf_we`=1, `rf_waddr`=3, `wsel`=1, `alu_sub`=0 in cycle 3.
- LOAD 12'b000_010_000_111 then STORE 12'b001_010_000_101 → cycle 3 `dmem_addr`=7, `rf_we`, `wsel`=0; cycle 6 `dmem_addr`=5, `dmem_we`, `rf_raddr_a`=2.
- HALT 12'hE00 at PC=4 → `halted`=1 from cycle 3, PC=5; `start` → FETCH at `imem_addr`=5.
- 16 NOPs from PC=0 → `imem_addr` wraps 15→0, no enables asserted.
- With `CU_SINGLE_STEP_EN`: `step` held 0 → `ir_ld` never asserts; one-cycle `step` pulse → exactly one instruction executes.
